// File: rtl/fifo_drain_if.sv
// Pop-side FIFO handshake plus registered valid/accept stream for fifo_drain.
// master drives the FIFO status and consumer accept; slave is the drain block.
interface fifo_drain_if #(
  parameter int W     = 32,
  parameter int CNT_W = 16
);
  logic             fifo_empty_r;
  logic [W-1:0]     fifo_pop_data;
  logic             fifo_pop;
  logic             flush;
  logic             out_vld_r;
  logic [W-1:0]     out_data_r;
  logic             out_accept;
  logic             idle_r;
  logic [CNT_W-1:0] out_cnt_r;

  modport master (
    output fifo_empty_r, fifo_pop_data, flush, out_accept,
    input  fifo_pop, out_vld_r, out_data_r, idle_r, out_cnt_r
  );

  modport slave (
    input  fifo_empty_r, fifo_pop_data, flush, out_accept,
    output fifo_pop, out_vld_r, out_data_r, idle_r, out_cnt_r
  );
endinterface

// File: rtl/fifo_drain.sv
// Drains a FIFO pop port into a registered valid/accept stream via a 2-entry
// skid buffer, so the pop strobe never depends on the downstream accept.
module fifo_drain #(
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  fifo_drain_if.slave   bus
);
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [W-1:0]     e0_q, e0_d;
  logic [W-1:0]     e1_q, e1_d;
  logic             vld_q, idle_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             put, take;

  // rst gates the strobe so the FIFO is never popped while held in reset.
  assign put  = rst & ~bus.fifo_empty_r & ~bus.flush & (state_q != ST_TWO);
  assign take = vld_q & bus.out_accept;

  always_comb begin
    state_d = state_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    cnt_d   = cnt_q + (take ? CNT_W'(1) : CNT_W'(0));
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (put) begin
            state_d = ST_ONE;
            e0_d    = bus.fifo_pop_data;
          end
        end
        ST_ONE: begin
          if (put && take) begin
            e0_d    = bus.fifo_pop_data;
          end else if (put) begin
            state_d = ST_TWO;
            e1_d    = bus.fifo_pop_data;
          end else if (take) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (take) begin
            state_d = ST_ONE;
            e0_d    = e1_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      e0_q    <= '0;
      e1_q    <= '0;
      vld_q   <= 1'b0;
      idle_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      vld_q   <= (state_d != ST_EMPTY);
      idle_q  <= (state_d == ST_EMPTY);
      cnt_q   <= cnt_d;
    end
  end

  assign bus.fifo_pop   = put;
  assign bus.out_vld_r  = vld_q;
  assign bus.out_data_r = e0_q;
  assign bus.idle_r     = idle_q;
  assign bus.out_cnt_r  = cnt_q;
endmodule

// File: tb/tb_fifo_drain.sv
// Directed bench for fifo_drain: a small FIFO model feeds the DUT, a negedge
// monitor checks delivery order and stall stability, directed steps check the rest.
module tb_fifo_drain;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_drain_if #(.W(32), .CNT_W(16)) bus ();
  fifo_drain_if #(.W(32), .CNT_W(4))  bus2 ();

  fifo_drain #(.W(32), .CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
  fifo_drain #(.W(32), .CNT_W(4))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // FIFO model: pointers never wrap in this short run, storage is modulo 64.
  logic [31:0] mem [64];
  int          rp = 0;
  int          wp = 0;
  logic [31:0] exp_q[$];

  assign bus.fifo_empty_r  = (rp == wp);
  assign bus.fifo_pop_data = mem[rp % 64];

  always @(posedge clk) begin
    if (bus.fifo_pop) rp <= rp + 1;
  end

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("  ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic push(input logic [31:0] d);
    mem[wp % 64] = d;
    wp = wp + 1;
    exp_q.push_back(d);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(rp == wp && bus.idle_r) && k < max);
    chk(tag, {31'd0, (rp == wp && bus.idle_r)}, 32'd1);
    chk({tag, "_allout"}, exp_q.size(), 0);
  endtask

  // Monitor: every delivered word must be the next one popped; data frozen while stalled.
  logic        prev_stall = 1'b0;
  logic        prev_flush = 1'b0;
  logic [31:0] prev_data  = '0;
  always @(negedge clk) begin
    if (rst) begin
      if (prev_stall && !prev_flush && bus.out_vld_r)
        chk("stable", bus.out_data_r, prev_data);
      if (bus.out_vld_r && bus.out_accept) begin
        if (exp_q.size() == 0) chk("extra_word", bus.out_data_r, 32'hDEAD_BEEF);
        else                   chk("order", bus.out_data_r, exp_q.pop_front());
      end
    end
    prev_stall <= rst && bus.out_vld_r && !bus.out_accept;
    prev_flush <= bus.flush;
    prev_data  <= bus.out_data_r;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n_rem;
    int rp0;
    bus.flush      = 1'b0;
    bus.out_accept = 1'b0;
    bus2.flush         = 1'b0;
    bus2.out_accept    = 1'b1;
    bus2.fifo_empty_r  = 1'b1;
    bus2.fifo_pop_data = 32'h0;

    // Reset values
    #12;
    chk("rst_vld",  bus.out_vld_r, 0);
    chk("rst_idle", bus.idle_r, 1);
    chk("rst_cnt",  bus.out_cnt_r, 0);
    chk("rst_data", bus.out_data_r, 0);
    step();
    rst = 1'b1;

    // Three words, always accepting: pop on 3 consecutive cycles, 1-cycle latency
    step();
    bus.out_accept = 1'b1;
    push(32'h11); push(32'h22); push(32'h33);
    @(negedge clk); chk("t1_pop0", bus.fifo_pop, 1);
    @(negedge clk); chk("t1_pop1", bus.fifo_pop, 1);
    chk("t1_lat", bus.out_data_r, 32'h11);
    @(negedge clk); chk("t1_pop2", bus.fifo_pop, 1);
    @(negedge clk); chk("t1_pop3", bus.fifo_pop, 0);
    wait_idle("t1_idle", 10);
    chk("t1_cnt", bus.out_cnt_r, 3);

    // Eight words with accept low: exactly two pops, then hold in TWO
    step();
    bus.out_accept = 1'b0;
    rp0 = rp;
    for (int i = 0; i < 8; i++) push(32'hA0 + i);
    repeat (3) @(negedge clk);
    chk("t2_pop_two", bus.fifo_pop, 0);
    chk("t2_head", bus.out_data_r, 32'hA0);
    repeat (2) @(negedge clk);
    chk("t2_pop_hold", bus.fifo_pop, 0);
    chk("t2_npop", rp - rp0, 2);
    step();
    bus.out_accept = 1'b1;
    wait_idle("t2_idle", 40);
    chk("t2_cnt", bus.out_cnt_r, 11);

    // Sixteen words with accept toggling every cycle
    step();
    bus.out_accept = 1'b1;
    for (int i = 0; i < 16; i++) push(32'hC0 + i);
    for (int k = 0; k < 80 && !(k > 2 && rp == wp && bus.idle_r); k++) begin
      step();
      bus.out_accept = ~bus.out_accept;
    end
    chk("t3_done", {31'd0, (rp == wp && bus.idle_r)}, 1);
    chk("t3_allout", exp_q.size(), 0);
    chk("t3_cnt", bus.out_cnt_r, 27);

    // Flush from TWO, then flush while EMPTY with the FIFO still non-empty
    step();
    bus.out_accept = 1'b0;
    push(32'h5); push(32'h6); push(32'h7);
    repeat (3) @(negedge clk);
    chk("t4_two_head", bus.out_data_r, 32'h5);
    step();
    bus.flush = 1'b1;
    exp_q.delete();
    exp_q.push_back(32'h7);
    @(negedge clk); chk("t4_pop_flush_two", bus.fifo_pop, 0);
    step();
    @(negedge clk);
    chk("t4_vld",  bus.out_vld_r, 0);
    chk("t4_idle", bus.idle_r, 1);
    chk("t4_cnt",  bus.out_cnt_r, 27);
    chk("t4_pop_flush_empty", bus.fifo_pop, 0);
    step();
    bus.flush = 1'b0;
    @(negedge clk); chk("t4_pop_after", bus.fifo_pop, 1);
    step();
    bus.out_accept = 1'b1;
    wait_idle("t4_idle_end", 10);
    chk("t4_cnt_end", bus.out_cnt_r, 28);

    // Asynchronous reset between edges mid-stream
    step();
    bus.out_accept = 1'b1;
    push(32'hB0); push(32'hB1); push(32'hB2); push(32'hB3);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("t5_vld",  bus.out_vld_r, 0);
    chk("t5_cnt",  bus.out_cnt_r, 0);
    chk("t5_idle", bus.idle_r, 1);
    chk("t5_pop",  bus.fifo_pop, 0);
    n_rem = wp - rp;
    chk("t5_remaining", n_rem, 1);
    exp_q.delete();
    for (int i = rp; i < wp; i++) exp_q.push_back(mem[i % 64]);
    step();
    chk("t5_pop_held", bus.fifo_pop, 0);
    rst = 1'b1;
    wait_idle("t5_idle", 10);
    chk("t5_cnt_after", bus.out_cnt_r, n_rem);

    // Narrow counter: 17 deliveries wrap a 4-bit count to 1
    step();
    bus2.fifo_empty_r = 1'b0;
    repeat (17) step();
    bus2.fifo_empty_r = 1'b1;
    repeat (2) step();
    @(negedge clk);
    chk("t6_wrap", bus2.out_cnt_r, 1);
    chk("t6_idle", bus2.idle_r, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/fifo_drain.md
Name: fifo_drain

Overview:
- Pop-side companion to the team's basic FIFO. It drains the FIFO's pop interface (empty flag, combinational pop data, pop strobe) into a registered valid/accept stream.
- It holds a 2-entry output skid buffer, so the FIFO pop decision never depends combinationally on the downstream accept.
- It sits between a FIFO and any valid/accept consumer, with full throughput of one word per cycle.

Parameters:
- W, 32, data width in bits; must match the attached FIFO width.
- CNT_W, 16, width of the delivered-word statistics counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- fifo_empty_r  in  1  registered empty flag from the FIFO.
- fifo_pop_data  in  W  FIFO head word; valid in the same cycle whenever fifo_empty_r=0.
- fifo_pop  out  1  pop strobe to the FIFO; combinational from local state and fifo_empty_r only.
- flush  in  1  synchronous discard of all buffered words.
- out_vld_r  out  1  output word valid (registered).
- out_data_r  out  W  output word (registered; head of skid buffer).
- out_accept  in  1  consumer takes the word this cycle when out_vld_r=1.
- idle_r  out  1  1 when the buffer is empty.
- out_cnt_r  out  CNT_W  count of words delivered (out_vld_r & out_accept); wraps at 2^CNT_W.

Behaviour:
- Reset (rst=0, asynchronous) values:
  - occupancy=EMPTY, out_vld_r=0, out_data_r=0, idle_r=1, out_cnt_r=0, second buffer entry=0.
  - While rst=0, fifo_pop must read 0.
- State machine on occupancy: EMPTY, ONE, TWO. Entry e0 drives out_data_r; e1 is the skid slot.
- Pop rule:
  - fifo_pop = ~fifo_empty_r & ~flush & (state != TWO).
  - No combinational path from out_accept to fifo_pop.
- Definitions:
  - take = out_vld_r & out_accept; out_accept is ignored when out_vld_r=0.
  - put = fifo_pop. The popped word is fifo_pop_data sampled on the same edge.
- Transitions when flush=0:
  - EMPTY: put -> ONE, e0<=data; else stay.
  - ONE, put & take -> ONE, e0<=data.
  - ONE, put & ~take -> TWO, e1<=data.
  - ONE, ~put & take -> EMPTY.
  - ONE, ~put & ~take -> stay.
  - TWO: put is impossible. take -> ONE, e0<=e1. ~take -> stay.
- Outputs derived from state:
  - out_vld_r = (state != EMPTY).
  - idle_r = (state == EMPTY); updated on the same edge as the state.
- Ordering: words leave in exact pop order; no loss, no duplication.
- Latency: a word popped at edge k is presented at out_vld_r after edge k, giving 1 cycle from pop to valid.
- Throughput: in steady state with the FIFO non-empty and out_accept=1, the buffer stays in ONE and delivers 1 word/cycle.
- Stability rule: while out_vld_r=1 and out_accept=0, out_data_r must not change.
- Flush:
  - flush=1 forces fifo_pop=0 that cycle.
  - Next state is EMPTY and out_vld_r drops.
  - A take in the same cycle still counts in out_cnt_r.
  - Flushing the FIFO itself is the caller's responsibility.
- Counter: out_cnt_r increments by 1 on each take, mod 2^CNT_W; flush does not clear it.
- Reset mid-operation: immediately returns to reset values; buffered words are lost.
- FIFO coupling: fifo_empty_r is trusted as-is. After the final pop the FIFO's registered empty rises on the same edge, so there is no overrun.

Test Plan:
- Reset, then push 0x11,0x22,0x33 into the FIFO with out_accept=1 constantly -> fifo_pop high 3 consecutive cycles; out_data_r = 0x11,0x22,0x33 on consecutive cycles, 1 cycle after each pop; out_cnt_r=3; idle_r returns to 1.
- Eight words queued, out_accept=0 -> exactly 2 pops (0xA0,0xA1), then state TWO with fifo_pop=0; out_data_r holds 0xA0 stable. Then release out_accept -> remaining words delivered in order 0xA0..0xA7, one per cycle.
- Backpressure toggling out_accept 1,0,1,0 over 16 words -> all 16 delivered in order, none duplicated; out_cnt_r=16; out_data_r never changes while stalled.
- Buffer in TWO (0x5,0x6), assert flush for 1 cycle with out_accept=0 -> next cycle out_vld_r=0, idle_r=1, fifo_pop=0 during the flush cycle, out_cnt_r unchanged.
- Assert rst low asynchronously mid-stream between clock edges -> out_vld_r=0 and out_cnt_r=0 immediately, without waiting for an edge; after release, the next FIFO word is delivered normally.
- CNT_W=4, deliver 17 words -> out_cnt_r wraps to 1.
